// File: rtl/fb_stream_reader.sv
// ---------------------------------------------------------------------------
// fb_stream_reader
//   Reader side of the framebuffer. Walks the RAM read port in linear order
//   starting at BASE_ADDR and turns the frame into a valid/ready pixel stream
//   with end-of-line and end-of-frame markers. It is independent of VGA scan
//   timing.
//
//   Optional build macro: FB_READER_THRESH_EN
//     Adds the thresh input. Each pixel is binarised when it enters the FIFO:
//     all-ones if pixel >= thresh, otherwise zero.
//
// Ports
//   clk       : clock (clk_vga domain)
//   reset     : asynchronous active-low reset
//   start     : one-cycle request to stream one frame (ignored while busy)
//   rd_addr   : RAM read address
//   rd_data   : RAM q, valid one cycle after rd_addr
//   thresh    : binarisation threshold (FB_READER_THRESH_EN only)
//   px_data   : pixel value
//   px_valid  : px_data valid
//   px_ready  : consumer accepts when px_valid && px_ready
//   px_eol    : head pixel is the last of its line
//   px_last   : head pixel is the last of the frame
//   busy      : frame in progress
//   done      : one-cycle pulse after the final pixel is accepted
// ---------------------------------------------------------------------------
module fb_stream_reader #(
    parameter int unsigned IMG_W  = 160,
    parameter int unsigned IMG_H  = 120,
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
`ifdef FB_READER_THRESH_EN
    input  logic [DATA_W-1:0] thresh,
`endif
    output logic [DATA_W-1:0] px_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              px_eol,
    output logic              px_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned X_W = $clog2(IMG_W);
    localparam int unsigned Y_W = $clog2(IMG_H);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic              r_pending;
    logic              r_pend_eol;
    logic              r_pend_last;
    logic              r_done;

    // Two-entry output FIFO: pixel plus its line/frame markers.
    logic [DATA_W-1:0] r_fifo_data [2];
    logic              r_fifo_eol  [2];
    logic              r_fifo_last [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    logic              w_valid;
    logic              w_pop;
    logic              w_issue;
    logic              w_issue_eol;
    logic              w_issue_last;
    logic              w_start_ok;
    logic              w_frame_end;
    logic [DATA_W-1:0] w_px_in;

    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid && px_ready;

    // Issue only if the pixel would still fit after this cycle's pop, counting
    // the read already in flight.
    assign w_issue = (r_state == S_RUN) &&
                     (({1'b0, r_count} + {2'b00, r_pending}) < (3'd2 + {2'b00, w_pop}));

    assign w_issue_eol  = (r_x == X_W'(IMG_W - 1));
    assign w_issue_last = w_issue_eol && (r_y == Y_W'(IMG_H - 1));

    // The done cycle is already IDLE, but a start landing on it is dropped.
    assign w_start_ok  = start && !r_done;
    assign w_frame_end = (r_state == S_DRAIN) && w_pop && r_fifo_last[r_rd_ptr];

`ifdef FB_READER_THRESH_EN
    assign w_px_in = (rd_data >= thresh) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
`else
    assign w_px_in = rd_data;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the next-state value is defaulted before the case so that no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok)               w_state_nxt = S_RUN;
            S_RUN:   if (w_issue && w_issue_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_frame_end)             w_state_nxt = S_IDLE;
            default:                              w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_addr     <= BASE_ADDR;
            r_x         <= '0;
            r_y         <= '0;
            r_pending   <= 1'b0;
            r_pend_eol  <= 1'b0;
            r_pend_last <= 1'b0;
            r_done      <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            // NOTE: the FIFO storage is reset because its head drives px_data,
            // px_eol and px_last directly and those outputs must read 0 in reset.
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_eol[i]  <= 1'b0;
                r_fifo_last[i] <= 1'b0;
            end
        end else begin
            r_done <= w_frame_end;

            if (r_state == S_IDLE && w_start_ok) begin
                rd_addr   <= BASE_ADDR;
                r_x       <= '0;
                r_y       <= '0;
                r_pending <= 1'b0;
            end else begin
                r_pending <= w_issue;
                if (w_issue) begin
                    rd_addr     <= rd_addr + ADDR_W'(1);
                    r_pend_eol  <= w_issue_eol;
                    r_pend_last <= w_issue_last;
                    if (w_issue_eol) begin
                        r_x <= '0;
                        if (!w_issue_last) r_y <= r_y + Y_W'(1);
                    end else begin
                        r_x <= r_x + X_W'(1);
                    end
                end
            end

            // rd_data this cycle belongs to the address issued last cycle.
            if (r_pending) begin
                r_fifo_data[r_wr_ptr] <= w_px_in;
                r_fifo_eol[r_wr_ptr]  <= r_pend_eol;
                r_fifo_last[r_wr_ptr] <= r_pend_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, r_pending} - {1'b0, w_pop};
        end
    end

    assign px_valid = w_valid;
    assign px_data  = r_fifo_data[r_rd_ptr];
    assign px_eol   = r_fifo_eol[r_rd_ptr];
    assign px_last  = r_fifo_last[r_rd_ptr];
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;

endmodule

// File: tb/tb_fb_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fb_stream_reader
//   Self-checking bench for fb_stream_reader. The RAM returns addr[7:0] one
//   cycle after the address. The expected stream is the pixel index sequence
//   0..IMG_W*IMG_H-1 with markers derived from the index.
// ---------------------------------------------------------------------------
module tb_fb_stream_reader;

    localparam int IMG_W  = 160;
    localparam int IMG_H  = 120;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int N_PX   = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] BASE_ADDR = '0;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] px_data;
    logic              px_valid;
    logic              px_ready;
    logic              px_eol;
    logic              px_last;
    logic              busy;
    logic              done;
`ifdef FB_READER_THRESH_EN
    logic [DATA_W-1:0] thresh = 8'h80;
`endif

    int checks = 0;
    int errors = 0;
    int k;

    fb_stream_reader #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
`ifdef FB_READER_THRESH_EN
        .thresh(thresh),
`endif
        .px_data(px_data),
        .px_valid(px_valid),
        .px_ready(px_ready),
        .px_eol(px_eol),
        .px_last(px_last),
        .busy(busy),
        .done(done)
    );

    always #20 clk = ~clk;

    // Synchronous RAM preloaded with addr[7:0].
    always @(posedge clk) rd_data <= rd_addr[7:0];

    // Expected {data, eol, last} of the idx-th pixel of a frame.
    function automatic logic [DATA_W+1:0] exp_px(input int idx);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        a = BASE_ADDR + ADDR_W'(idx);
        d = a[7:0];
`ifdef FB_READER_THRESH_EN
        d = (d >= thresh) ? 8'hFF : 8'h00;
`endif
        return {d, (idx % IMG_W) == IMG_W - 1, idx == N_PX - 1};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
    endtask

    // mode 0: ready always high; 1: ready random 50%; 2: ready low for the
    // first 20 cycles then high. Stops after max_px pixels (0 = whole frame,
    // returning on the negedge where the done pulse was checked).
    task automatic run_stream(input int max_px, input int mode, input int start_at,
                              input bit chk_latency);
        int                cyc = 0;
        int                first_valid = -1;
        bit                finished = 1'b0;
        bit                fired = 1'b0;
        bit                stall_prev = 1'b0;
        bit                done_exp = 1'b0;
        bit                hs;
        logic [DATA_W+1:0] held = '0;
        logic [ADDR_W-1:0] addr_hold = '0;
        k = 0;
        while (!finished && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (start_at >= 0 && k == start_at && !fired) begin
                start = 1'b1;
                fired = 1'b1;
            end
            case (mode)
                0:       px_ready = 1'b1;
                1:       px_ready = 1'($urandom_range(0, 1));
                default: px_ready = (cyc > 20);
            endcase

            check_eq("busy_done", {30'd0, busy, done}, {30'd0, !done_exp, done_exp});
            if (done_exp) finished = 1'b1;

            if (first_valid < 0 && px_valid) first_valid = cyc;

            if (stall_prev)
                check_eq("stall_stable", {21'd0, px_valid, px_data, px_eol, px_last},
                         {21'd0, 1'b1, held});

            if (mode == 2 && cyc == 5) addr_hold = rd_addr;
            if (mode == 2 && cyc == 20) begin
                check_eq("stall_addr_le2", 32'(rd_addr - BASE_ADDR <= 2), 32'd1);
                check_eq("stall_addr_hold", 32'(rd_addr), 32'(addr_hold));
            end

            hs = px_valid && px_ready;
            done_exp = 1'b0;
            if (hs) begin
                check_eq($sformatf("pixel_%0d", k), {22'd0, px_data, px_eol, px_last},
                         {22'd0, exp_px(k)});
                done_exp = (k == N_PX - 1);
                k++;
            end
            stall_prev = px_valid && !px_ready;
            held = {px_data, px_eol, px_last};

            if (max_px > 0 && k >= max_px) finished = 1'b1;
        end
        if (!finished) check_eq("stream_timeout", 32'(k), 32'(N_PX));
        if (max_px == 0) check_eq("pixel_count", 32'(k), 32'(N_PX));
        // start sampled at edge 0, address issued edge 1, data captured edge 2;
        // the pixel is first visible at the third negedge after start.
        if (chk_latency) check_eq("first_valid_cycle", 32'(first_valid), 32'd3);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        px_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_state", {7'd0, rd_addr, px_data, px_valid, px_eol, px_last, busy, done},
                 {7'd0, BASE_ADDR, 8'd0, 5'd0});
        reset = 1'b1;

        // Frame 1: ready held high.
        start_frame();
        run_stream(0, 0, -1, 1'b1);
        // A start on the done cycle must be ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_on_done_ignored", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("idle_after_frame1", {30'd0, busy, px_valid}, 32'd0);

        // Frame 2: random ready, extra start at pixel 500.
        start_frame();
        run_stream(0, 1, 500, 1'b1);
        repeat (5) @(negedge clk);
        check_eq("single_done_frame2", {30'd0, busy, done}, 32'd0);

        // Frame 3: stall 20 cycles, then run to pixel 1000 and reset mid-frame.
        start_frame();
        run_stream(1000, 2, -1, 1'b0);
        #5 reset = 1'b0;
        #1;
        check_eq("async_reset_outputs", {7'd0, rd_addr, px_data, px_valid, px_eol, px_last, busy, done},
                 {7'd0, BASE_ADDR, 8'd0, 5'd0});
        @(negedge clk);
        reset = 1'b1;

        // Restart after abort must begin again at pixel 0.
        start_frame();
        run_stream(300, 0, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
